load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum cycles spent waiting for mem_ack (legal range 1..255).
REQ-002 SHALL have one clock and a synchronous, active-high reset, listed first as ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
REQ-003 SHALL have the following core-side ports:
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept a request.
- req_memread  input  1  load request.
- req_memwrite  input  1  store request.
- req_memtoreg  input  1  select loaded data as the result.
- req_address  input  32  word address, or ALU result.
- req_writedata  input  32  store data.
- resp_valid  output  1  one-cycle result strobe.
- resp_result  output  32  result for register writeback.
- resp_error  output  1  timeout or fault flag, qualified by resp_valid.
REQ-004 SHALL have the following memory-side ports:
- mem_address  output  32  held address.
- mem_writedata  output  32  held store data.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe.
- mem_ack  input  1  access complete; mem_readdata valid in the same cycle.
- mem_readdata  input  32  load data.

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE, when req_valid=1 the unit SHALL capture all req_* fields on that edge.
REQ-007 Capture transitions:
- If req_memwrite=1 or req_memread=1, next state is ACCESS.
- Otherwise next state is RESP with result=req_address.
REQ-008 If req_memread=1 and req_memwrite=1 together, the request SHALL be treated as a store only: mem_write=1, mem_read=0.
REQ-009 In ACCESS, mem_read or mem_write SHALL be held at 1 and mem_address/mem_writedata SHALL be stable until mem_ack=1 or timeout.
REQ-010 Outside ACCESS, mem_read and mem_write SHALL be 0.
REQ-011 In ACCESS, an 8-bit wait counter SHALL clear on entry and increment each cycle mem_ack=0.
REQ-012 On mem_ack=1 in ACCESS, the next state SHALL be RESP, and the result SHALL be:
- mem_readdata, if the request was a load with memtoreg=1;
- the captured address, otherwise (including all stores).
REQ-013 When the wait counter reaches TIMEOUT_CYCLES without ack, the strobes SHALL drop and the next state SHALL be RESP with resp_error=1 and resp_result=0.
REQ-014 In RESP, resp_valid SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-015 resp_result and resp_error SHALL hold their last values until the next RESP.
REQ-016 Latency SHALL be: request accepted at edge T, strobes high in cycle T+1, ack in T+1 gives resp_valid in T+2.
REQ-017 A non-memory request SHALL produce resp_valid in T+1.
REQ-018 A new request SHALL be accepted no earlier than the IDLE cycle following RESP.
REQ-019 mem_ack received outside ACCESS SHALL be ignored.

Reset
REQ-020 reset=1 at a clock edge SHALL force:
- state IDLE;
- req_ready=1;
- resp_valid=0, resp_result=0, resp_error=0;
- mem_read=0, mem_write=0;
- mem_address=0, mem_writedata=0;
- wait counter=0.
REQ-021 Reset during ACCESS SHALL abandon the transaction, with no resp_valid for it; strobes SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-022 Macro LSU_ALIGN_CHECK_EN defined: a memory request with req_address[1:0]!=0 SHALL skip ACCESS and go to RESP with resp_error=1 and resp_result=req_address; no strobe SHALL assert.
REQ-023 Macro LSU_ALIGN_CHECK_EN undefined: no alignment check; the address SHALL pass through unmodified.

Verification
REQ-024 Load: memread=1, memtoreg=1, address=0x10; mem_ack in the first ACCESS cycle with readdata=0xDEADBEEF -> mem_read=1 for 1 cycle, resp_valid at T+2, result=0xDEADBEEF, error=0.
REQ-025 Store with delay: memwrite=1, address=0x04, writedata=0x12345678; ack after 3 wait cycles -> mem_write held 4 cycles with address and data stable, result=0x04.
REQ-026 ALU pass-through: memread=0, memwrite=0, address=0x55 -> no strobe, resp_valid at T+1, result=0x55.
REQ-027 Timeout: TIMEOUT_CYCLES=4, load with mem_ack never asserted -> strobe drops after 4 cycles, resp_valid=1 with error=1 and result=0.
REQ-028 Reset in ACCESS: reset pulsed in the 2nd ACCESS cycle -> strobes 0 next cycle, resp_valid stays 0, req_ready=1.
REQ-029 Alignment with LSU_ALIGN_CHECK_EN: load at 0x13 -> no mem_read, error=1, result=0x13; without the macro -> normal access at 0x13.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core/memory signal bundle for load_store_unit.
// slave = the unit, master = core plus memory model driving it.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_memread;
    logic        req_memwrite;
    logic        req_memtoreg;
    logic [31:0] req_address;
    logic [31:0] req_writedata;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ack;
    logic [31:0] mem_readdata;

    modport slave (
        input  req_valid, req_memread, req_memwrite, req_memtoreg,
        input  req_address, req_writedata, mem_ack, mem_readdata,
        output req_ready, resp_valid, resp_result, resp_error,
        output mem_address, mem_writedata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_memread, req_memwrite, req_memtoreg,
        output req_address, req_writedata, mem_ack, mem_readdata,
        input  req_ready, resp_valid, resp_result, resp_error,
        input  mem_address, mem_writedata, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP with ack timeout.
// Define LSU_ALIGN_CHECK_EN to fault misaligned memory requests without access.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [7:0] LastWait = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        m2r_q, m2r_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        error_q, error_d;
    logic        is_mem;
    logic        misaligned;

    assign is_mem = bus.req_memread | bus.req_memwrite;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = bus.req_address[1:0] != 2'b00;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        m2r_d    = m2r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_address;
                    wdata_d = bus.req_writedata;
                    // a simultaneous read+write is carried out as a store
                    wr_d    = bus.req_memwrite;
                    rd_d    = bus.req_memread & ~bus.req_memwrite;
                    m2r_d   = bus.req_memtoreg;
                    cnt_d   = 8'd0;
                    if (is_mem && !misaligned) begin
                        state_d = ACCESS;
                    end else begin
                        state_d  = RESP;
                        result_d = bus.req_address;
                        error_d  = is_mem;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_d  = RESP;
                    error_d  = 1'b0;
                    result_d = (rd_q && m2r_q) ? bus.mem_readdata : addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LastWait) begin
                        state_d  = RESP;
                        result_d = 32'd0;
                        error_d  = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            m2r_q    <= 1'b0;
            cnt_q    <= 8'd0;
            result_q <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            m2r_q    <= m2r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign bus.req_ready     = state_q == IDLE;
    assign bus.resp_valid    = state_q == RESP;
    assign bus.resp_result   = result_q;
    assign bus.resp_error    = error_q;
    assign bus.mem_address   = addr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.mem_read      = (state_q == ACCESS) && rd_q;
    assign bus.mem_write     = (state_q == ACCESS) && wr_q;

endmodule
